shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
Command-driven controller for the 8-bit shift register datapath (9-bit register: 8 data bits plus a flag bit). It accepts a command {data, direction, amount} over a valid/ready handshake. It then drives the datapath select/data inputs to load the operand and apply N single-bit shifts, captures the shifted byte and flag, and returns them over a valid/ready result handshake. It sits between the instruction decode/control logic and the shifter instance, and is the only driver of the shifter's select and data-in inputs.

Parameters:
DATA_W, 8, operand/result width; must match shifter data width.
AMT_W, 4, width of the shift-amount field.
MAX_SHIFT, 8, amounts above this clamp to MAX_SHIFT.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  high only in IDLE
cmd_data  input  DATA_W  operand to load
cmd_dir  input  1  0 = shift right, 1 = shift left
cmd_amt  input  AMT_W  number of single-bit shifts
sh_s  output  2  shifter select: 00 hold, 01 right, 10 left, 11 load
sh_din  output  DATA_W  shifter load data
sh_so  input  DATA_W  shifter data out
sh_flag  input  1  shifter flag out
res_valid  output  1  result available
res_ready  input  1  result consumed
res_data  output  DATA_W  captured shifter data
res_flag  output  1  captured shifter flag
busy  output  1  high in any state other than IDLE
ones_cnt  output  AMT_W  ones shifted out (optional feature)

Behaviour:
- States: IDLE, LOAD, SHIFT, CAPTURE, DONE. Register reset to IDLE.
- sh_s and sh_din are combinational decodes of state and latched command:
  - IDLE, CAPTURE, DONE: sh_s=00.
  - LOAD: sh_s=11, sh_din=latched data.
  - SHIFT: sh_s=01 if dir=0, 10 if dir=1.
  - sh_din = latched data in all states.
- IDLE: cmd_ready=1. On cmd_valid:
  - Latch data and dir.
  - Latch amt clamped to MAX_SHIFT.
  - Go to LOAD.
- LOAD: 1 cycle. Shifter loads at the cycle's closing edge. Remaining-count register = clamped amt. Next state is SHIFT if amt != 0, else CAPTURE.
- SHIFT: one cycle per shift. Decrement remaining each cycle; go to CAPTURE when remaining reaches 1. Exactly amt shift edges are applied.
- CAPTURE: 1 cycle with sh_s=00. At the closing edge:
  - res_data <= sh_so, res_flag <= sh_flag.
  - res_valid <= 1; go to DONE.
- DONE: hold res_valid=1 and result stable until res_ready=1. On that edge res_valid <= 0 and the FSM goes to IDLE.
- No new command is accepted before returning to IDLE; there is no back-to-back overlap.
- Latency: command accepted at edge E0, res_valid rises at edge E0+amt+2. The amt=0 case gives E0+2.
- Flag semantics follow the shifter:
  - Right shift: flag = last bit shifted out.
  - Left shift: flag unchanged from its prior value.
  - Load does not clear the flag.
- Reset values: state=IDLE, cmd_ready=1 (combinational from IDLE), busy=0, sh_s=00, res_valid=0, res_data=0, res_flag=0, ones_cnt=0, latched fields=0.
- Reset mid-operation returns immediately to IDLE with sh_s=00. Any in-flight result is discarded.
- cmd_valid is ignored outside IDLE.
- res_ready is ignored outside DONE.

Optional Feature:
SHSEQ_ONES_COUNT_EN
- Defined:
  - ones_cnt clears in LOAD.
  - During each SHIFT cycle with dir=0, ones_cnt increments if bit 0 of sh_so is 1 (the bit about to become the flag).
  - ones_cnt is captured and held with the result; it updates only in LOAD/SHIFT.
  - Left shifts leave it at 0.
- Not defined: ones_cnt is tied to 0 and the counter logic is absent.

Test Plan:
- Right shift: data=0xB5, dir=0, amt=3 → res_data=0x16, res_flag=1, res_valid rises 5 edges after accept; with the feature enabled, ones_cnt=2.
- Left shift (follows the right-shift test, flag=1): data=0xB5, dir=1, amt=2 → res_data=0xD4, res_flag=1 (unchanged), sh_s=10 for exactly 2 cycles.
- amt=0, data=0x3C → one LOAD cycle, no SHIFT cycles, res_data=0x3C, res_valid 2 edges after accept.
- Clamp: data=0xFF, dir=0, amt=12 → 8 shift cycles, res_data=0x00, res_flag=1, ones_cnt=8 with the feature enabled.
- Backpressure: hold res_ready=0 for 10 cycles in DONE → res_valid and res_data stable, cmd_ready=0, and a cmd_valid pulse is ignored; res_ready=1 → IDLE on the next edge.
- Reset mid-SHIFT (amt=6, assert rst after 2 shifts) → state IDLE, sh_s=00, res_valid=0; a subsequent command executes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: command-driven controller for an 8-bit shift register
// datapath (8 data bits + flag). Accepts {data, dir, amt} over a valid/ready
// handshake, loads the operand into the shifter, applies amt single-bit
// shifts (clamped to MAX_SHIFT), captures the shifter output and returns it
// over a valid/ready result handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_data/cmd_dir/cmd_amt operand, direction (0 right, 1 left), amount
//   sh_s/sh_din              shifter select (00 hold,01 right,10 left,11 load)
//                            and load data
//   sh_so/sh_flag            shifter data and flag outputs
//   res_valid/res_ready      result handshake
//   res_data/res_flag        captured shifter data and flag
//   busy                     high whenever not IDLE
//   ones_cnt                 ones shifted out on right shifts
//
// Build option: define SHSEQ_ONES_COUNT_EN to enable the ones counter;
// otherwise ones_cnt is tied to zero.

module shift_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned AMT_W     = 4,
  parameter int unsigned MAX_SHIFT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_dir,
  input  logic [AMT_W-1:0]  cmd_amt,
  output logic [1:0]        sh_s,
  output logic [DATA_W-1:0] sh_din,
  input  logic [DATA_W-1:0] sh_so,
  input  logic              sh_flag,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_flag,
  output logic              busy,
  output logic [AMT_W-1:0]  ones_cnt
);

  localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAX_SHIFT);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dir_q, dir_d;
  logic [AMT_W-1:0]    amt_q, amt_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                res_flag_q, res_flag_d;
  logic                res_valid_q, res_valid_d;
  logic [AMT_W-1:0]    amt_clamped;

`ifdef SHSEQ_ONES_COUNT_EN
  logic [AMT_W-1:0]    ones_q, ones_d;
`endif

  assign amt_clamped = (cmd_amt > MAX_AMT) ? MAX_AMT : cmd_amt;

  // Next-state and datapath-register computation.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    dir_d       = dir_q;
    amt_d       = amt_q;
    rem_d       = rem_q;
    res_data_d  = res_data_q;
    res_flag_d  = res_flag_q;
    res_valid_d = res_valid_q;
`ifdef SHSEQ_ONES_COUNT_EN
    ones_d      = ones_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          amt_d   = amt_clamped;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rem_d   = amt_q;
`ifdef SHSEQ_ONES_COUNT_EN
        ones_d  = '0;
`endif
        state_d = (amt_q != '0) ? S_SHIFT : S_CAPTURE;
      end
      S_SHIFT: begin
        rem_d = rem_q - AMT_W'(1);
`ifdef SHSEQ_ONES_COUNT_EN
        // bit 0 is the one leaving the register on this right-shift edge
        if (!dir_q && sh_so[0]) begin
          ones_d = ones_q + AMT_W'(1);
        end
`endif
        if (rem_q == AMT_W'(1)) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        res_data_d  = sh_so;
        res_flag_d  = sh_flag;
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      dir_q       <= 1'b0;
      amt_q       <= '0;
      rem_q       <= '0;
      res_data_q  <= '0;
      res_flag_q  <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef SHSEQ_ONES_COUNT_EN
      ones_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      amt_q       <= amt_d;
      rem_q       <= rem_d;
      res_data_q  <= res_data_d;
      res_flag_q  <= res_flag_d;
      res_valid_q <= res_valid_d;
`ifdef SHSEQ_ONES_COUNT_EN
      ones_q      <= ones_d;
`endif
    end
  end

  // Shifter select decode from state and latched direction.
  always_comb begin
    sh_s = SEL_HOLD;
    case (state_q)
      S_LOAD:  sh_s = SEL_LOAD;
      S_SHIFT: sh_s = dir_q ? SEL_LEFT : SEL_RIGHT;
      default: sh_s = SEL_HOLD;
    endcase
  end

  assign sh_din    = data_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_flag  = res_flag_q;

`ifdef SHSEQ_ONES_COUNT_EN
  assign ones_cnt = ones_q;
`else
  assign ones_cnt = '0;
`endif

endmodule
